// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Purpose : bundles the instruction-memory request/response channel and the
//           decode-side presentation/control signals of the fetch stage.
// Signals :
//   imem_req/imem_addr        fetch -> memory request (valid + address)
//   imem_ready                memory -> fetch, request accepted this cycle
//   imem_rvalid/imem_rdata    memory -> fetch, in-order response
//   stall                     decode -> fetch, decode cannot consume
//   redirect/redirect_pc      execute -> fetch, branch taken + target
//   inst/inst_pc/inst_valid   fetch -> decode, head of the fetch buffer
//   misalign                  fetch -> execute, misaligned redirect target
// Modports: master = fetch stage, slave = surrounding memory/decode/execute.
// ---------------------------------------------------------------------------
interface inst_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        misalign;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, misalign,
    input  imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, misalign,
    output imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Purpose : instruction-fetch stage. Keeps the PC, issues word requests to an
//           in-order instruction memory, buffers returned words with their PCs
//           in a small FIFO and presents the head to decode. A branch redirect
//           flushes the buffer and discards responses still in flight.
// Ports   :
//   CLK     clock, all state updates on posedge
//   reset   asynchronous active-low reset
//   bus     inst_fetch_if.master (memory channel + decode/execute signals)
// Params  :
//   RESET_PC    PC after reset (4-byte aligned)
//   FIFO_DEPTH  fetch-buffer entries, power of two 2..16
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0000000000000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         reset,
  inst_fetch_if.master bus
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [63:0]   r_pc;
  logic [63:0]   r_rsp_pc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic          r_misalign;
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic [63:0]   r_mem_pc   [FIFO_DEPTH];

  logic [CW:0]   w_used;
  logic          w_credit;
  logic          w_req;
  logic          w_accept;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [CW-1:0] w_outst_after;
  logic [63:0]   w_redir_pc;

  // Credit: buffered entries plus requests in flight never exceed the FIFO,
  // so every response has a slot waiting for it.
  assign w_used   = {1'b0, r_count} + {1'b0, r_outst};
  assign w_credit = w_used < (CW+1)'(FIFO_DEPTH);
  assign w_req    = reset & ~bus.redirect & w_credit;
  assign w_accept = w_req & bus.imem_ready;

  // A response with nothing outstanding is stale (e.g. issued before reset).
  assign w_rsp  = bus.imem_rvalid & (r_outst != '0);
  assign w_push = w_rsp & (r_drop == '0) & ~bus.redirect;
  assign w_valid = (r_count != '0);
  assign w_pop  = w_valid & ~bus.stall & ~bus.redirect;

  assign w_outst_after = r_outst - CW'(w_rsp);
  assign w_redir_pc    = {bus.redirect_pc[63:2], 2'b00};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= bus.redirect & (|bus.redirect_pc[1:0]);
      if (bus.redirect) begin
        // No request goes out in a redirect cycle, so only the response
        // decrement affects outstanding; everything still in flight is dropped.
        r_pc     <= w_redir_pc;
        r_rsp_pc <= w_redir_pc;
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_count  <= '0;
        r_outst  <= w_outst_after;
        r_drop   <= w_outst_after;
      end else begin
        if (w_accept) r_pc <= r_pc + 64'd4;
        r_outst <= w_outst_after + CW'(w_accept);
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_wptr   <= r_wptr + AW'(1);
          r_rsp_pc <= r_rsp_pc + 64'd4;
        end
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge CLK) begin
    if (reset && w_push) begin
      r_mem_data[r_wptr] <= bus.imem_rdata;
      r_mem_pc[r_wptr]   <= r_rsp_pc;
    end
  end

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_valid ? r_mem_data[r_rptr] : NOP;
  assign bus.inst_pc    = w_valid ? r_mem_pc[r_rptr] : 64'd0;
  assign bus.misalign   = r_misalign;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage. Keeps the program counter and issues word requests to the instruction memory, which returns responses in order. Buffers the returned words with their PCs in a small FIFO. Presents one instruction per cycle to decode, holds it while decode stalls, and flushes on a branch redirect from execute.

Parameters:
RESET_PC, 64'h0000000000000000, PC loaded on reset (must be 4-byte aligned)
FIFO_DEPTH, 4, fetch-buffer entries; power of two, 2..16

Ports:
CLK  input  1  clock; all state updates on posedge
reset  input  1  asynchronous active-low reset
imem_req  output  1  request valid this cycle (combinational)
imem_addr  output  64  request address = current PC
imem_ready  input  1  memory accepts the request this cycle (handshake = imem_req & imem_ready)
imem_rvalid  input  1  response valid; in order, at least 1 cycle after acceptance
imem_rdata  input  32  response instruction word
stall  input  1  decode cannot consume (decode's stall_raise)
redirect  input  1  branch taken; flush the fetch stage
redirect_pc  input  64  new fetch PC when redirect=1
inst  output  32  FIFO head word; 32'h00000013 (NOP) when the FIFO is empty
inst_pc  output  64  PC of inst; 0 when the FIFO is empty
inst_valid  output  1  FIFO non-empty
misalign  output  1  registered one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop=0; misalign=0.
  - Therefore inst=32'h00000013, inst_pc=0, inst_valid=0, imem_req=0 while reset is low.
- Credit rule: imem_req = reset & !redirect & (count + outstanding < FIFO_DEPTH).
  - The FIFO can never overflow, so no full-drop logic is needed.
- Accepted request (imem_req & imem_ready): pc <= pc+4 (64-bit wrap); outstanding +1.
- Response (imem_rvalid):
  - Always decrements outstanding.
  - If drop>0: discard the word and decrement drop.
  - Otherwise push {pc_tag, imem_rdata}. pc_tag comes from an internal response-PC counter that advances by 4 on every non-dropped push.
- Pop when inst_valid & !stall & !redirect. The head advances on the next posedge.
- Stall: head, inst and inst_pc hold stable. Fetching continues until credits run out.
- Stall with an empty FIFO: no pop; the NOP is presented.
- Simultaneous push and pop: both apply; count unchanged.
- Simultaneous accept and response: outstanding unchanged.
- Redirect (highest priority, registered on the same posedge):
  - FIFO cleared (count=0, pointers reset).
  - pc and the response-PC counter <= {redirect_pc[63:2], 2'b00}.
  - drop <= outstanding after this cycle's response decrement, i.e. responses still in flight are discarded.
  - Any response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - misalign <= |redirect_pc[1:0].
- Redirect while drop>0: drop is recomputed the same way; it never double-counts.
- FIFO pointers are log2(FIFO_DEPTH)-bit and wrap naturally. count is log2(FIFO_DEPTH)+1 bits. outstanding and drop are the same width as count.
- Latency: an instruction accepted at posedge N appears on inst at earliest 1 cycle after its rvalid edge, since the FIFO output is registered storage.
- Reset asserted mid-burst: all state clears immediately. Responses arriving after reset deasserts with outstanding=0 are ignored; the memory is also reset.

Test Plan:
- Reset release, RESET_PC=0x1000, memory with 1-cycle latency returning 0x00a00093, 0x00100113, ... → imem_addr sequence 0x1000, 0x1004, 0x1008; inst_pc=0x1000 with inst=0x00a00093 two cycles after the first acceptance; inst_valid=1.
- Hold stall=1 for 6 cycles with an always-ready memory → exactly 4 requests issued (FIFO_DEPTH), then imem_req=0; inst/inst_pc frozen. Releasing stall pops one entry per cycle in PC order.
- Memory latency 3 cycles, 3 requests outstanding, redirect=1 with redirect_pc=0x2000 → FIFO empty next cycle (inst=0x00000013); the 3 late responses are discarded; the first presented inst_pc=0x2000.
- redirect_pc=0x2006 → next fetch address 0x2004; misalign pulses high for exactly one cycle.
- imem_ready=0 for 5 cycles → imem_addr held constant and pc not incremented; inst_valid drops to 0 once the FIFO drains; NOP presented.
- Assert reset mid-stream with 2 entries buffered and 1 outstanding → outputs go to reset values asynchronously; after release, fetch restarts at RESET_PC.
